// File: rtl/clk_tick_gen.sv
// Multi-channel programmable clock divider / tick generator on clk_in.
// Each channel counts to its divisor N and emits a wrap tick plus a toggled or pulsed clock.
module clk_tick_gen #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 26,
  parameter int DEFAULT_DIV = 330000,
  localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic              div_wr,
  input  logic [SEL_W-1:0]  div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_active;
    logic [CNT_W-1:0] div_shadow;
    logic [CNT_W-1:0] last;
    logic             pending;
    logic             out_q;
    logic             tick_q;
    logic             term;
    logic             wr_hit;

    // A divisor of 0 behaves like 1: the channel wraps on every enabled cycle.
    always_comb begin
      last = (div_active == '0) ? '0 : div_active - CNT_W'(1);
    end

    assign term   = en[c] && (cnt == last);
    assign wr_hit = div_wr && (div_sel == SEL_W'(c));

    always_ff @(posedge clk_in) begin
      if (rst) begin
        cnt        <= '0;
        div_active <= DEF_DIV;
        div_shadow <= DEF_DIV;
        pending    <= 1'b0;
        out_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        tick_q <= term;
        if (term) begin
          cnt <= '0;
          if (pending) begin
            div_active <= div_shadow;
            pending    <= 1'b0;
          end
        end else if (en[c]) begin
          cnt <= cnt + CNT_W'(1);
        end
        // A write on the wrap edge lands after the swap, so it waits for the next wrap.
        if (wr_hit) begin
          div_shadow <= div_val;
          pending    <= 1'b1;
        end
        if (mode[c]) begin
          out_q <= term;
        end else if (term) begin
          out_q <= ~out_q;
        end
      end
    end

    assign clk_out[c] = out_q;
    assign tick[c]    = tick_q;
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Self-checking bench for clk_tick_gen: table vectors, a reference-model scoreboard,
// and hand-derived tick/clk_out patterns for divisor-change, disable and reset cases.
module tb_clk_tick_gen;

  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 4;

  logic             clk_in = 1'b0;
  logic             rst;
  logic [1:0]       en;
  logic [1:0]       mode;
  logic             div_wr;
  logic [0:0]       div_sel;
  logic [CNT_W-1:0] div_val;
  logic [1:0]       clk_out;
  logic [1:0]       tick;

  logic [2:0]       en3;
  logic [2:0]       mode3;
  logic             div_wr3;
  logic [1:0]       div_sel3;
  logic [CNT_W-1:0] div_val3;
  logic [2:0]       clk_out3;
  logic [2:0]       tick3;

  always #5 clk_in = ~clk_in;

  clk_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .mode(mode), .div_wr(div_wr),
    .div_sel(div_sel), .div_val(div_val), .clk_out(clk_out), .tick(tick)
  );

  // Three channels give a 2-bit select, so index 3 is a representable out-of-range write.
  clk_tick_gen #(.NUM_CH(3), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut3 (
    .clk_in(clk_in), .rst(rst), .en(en3), .mode(mode3), .div_wr(div_wr3),
    .div_sel(div_sel3), .div_val(div_val3), .clk_out(clk_out3), .tick(tick3)
  );

  typedef struct {
    logic [1:0] tick;
    logic [1:0] out;
    logic [2:0] tick3;
  } exp_t;

  typedef struct {
    logic       r;
    logic [1:0] e;
    logic [1:0] m;
    logic [1:0] exp_tick;
    logic [1:0] exp_out;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[21];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   k        = 0;

  int   m_cnt[2];
  int   m_act[2];
  int   m_sh[2];
  bit   m_pend[2];
  bit   m_out[2];
  bit   m_tick[2];

  logic tick0_log[256];
  logic out0_log[256];
  logic tick1_log[256];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, k);
    end
  endtask

  // Reference model of one rising edge, written from the channel behaviour description.
  task automatic modelStep(input logic r, input logic [1:0] e, input logic [1:0] m,
                           input logic wr, input int sel, input int val, output exp_t x);
    int nk;
    nk = r ? 0 : k + 1;
    for (int c = 0; c < 2; c++) begin
      if (r) begin
        m_cnt[c] = 0; m_act[c] = DEFAULT_DIV; m_sh[c] = DEFAULT_DIV;
        m_pend[c] = 0; m_out[c] = 0; m_tick[c] = 0;
      end else begin
        int  n;
        bit  t;
        n = (m_act[c] == 0) ? 1 : m_act[c];
        t = e[c] && (m_cnt[c] == n - 1);
        if (t) begin
          m_cnt[c] = 0;
          if (m_pend[c]) begin
            m_act[c]  = m_sh[c];
            m_pend[c] = 0;
          end
        end else if (e[c]) begin
          m_cnt[c] = m_cnt[c] + 1;
        end
        if (wr && sel == c) begin
          m_sh[c]   = val;
          m_pend[c] = 1;
        end
        m_tick[c] = t;
        m_out[c]  = m[c] ? t : (t ? !m_out[c] : m_out[c]);
      end
    end
    x.tick  = {m_tick[1], m_tick[0]};
    x.out   = {m_out[1], m_out[0]};
    x.tick3 = (nk > 0 && nk % 4 == 0) ? 3'b111 : 3'b000;
  endtask

  task automatic checkOutput();
    exp_t x;
    if (sb.size() == 0) begin
      checkVal("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    x = sb.pop_front();
    checkVal("tick", {30'd0, tick}, {30'd0, x.tick});
    checkVal("clk_out", {30'd0, clk_out}, {30'd0, x.out});
    checkVal("tick_badsel", {29'd0, tick3}, {29'd0, x.tick3});
    if (k < 256) begin
      tick0_log[k] = tick[0];
      out0_log[k]  = clk_out[0];
      tick1_log[k] = tick[1];
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] e, input logic [1:0] m,
                               input logic wr, input int sel, input int val);
    exp_t x;
    rst     = r;
    en      = e;
    mode    = m;
    div_wr  = wr;
    div_sel = 1'(sel);
    div_val = CNT_W'(val);
    modelStep(r, e, m, wr, sel, val, x);
    sb.push_back(x);
    k = r ? 0 : k + 1;
    @(posedge clk_in);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n, input logic [1:0] e, input logic [1:0] m);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, e, m, 1'b0, 0, 0);
  endtask

  // Bit i of exp is the expected value at cycle from+i.
  task automatic checkSeq(input string name, input int which, input int from, input int to,
                          input logic [31:0] exp);
    logic [31:0] act;
    act = '0;
    for (int i = from; i <= to; i++) begin
      case (which)
        0:       act[i-from] = tick0_log[i];
        1:       act[i-from] = out0_log[i];
        default: act[i-from] = tick1_log[i];
      endcase
    end
    checkVal(name, act, exp);
  endtask

  initial begin
    en3 = 3'b111; mode3 = 3'b000; div_wr3 = 1'b1; div_sel3 = 2'd3; div_val3 = 8'd2;
    rst = 1'b1; en = 2'b00; mode = 2'b00; div_wr = 1'b0; div_sel = 1'b0; div_val = '0;

    // Cycle 0 is reset; toggle mode through cycle 12, then channel 1 switches to pulse.
    for (int i = 0; i < 21; i++) begin
      logic o0, o1;
      vecs[i].r        = (i == 0);
      vecs[i].e        = 2'b11;
      vecs[i].m        = (i <= 12) ? 2'b00 : 2'b10;
      vecs[i].exp_tick = (i > 0 && i % 4 == 0) ? 2'b11 : 2'b00;
      o0 = ((i / 4) % 2) == 1;
      o1 = (i <= 12) ? o0 : (i > 0 && i % 4 == 0);
      vecs[i].exp_out  = {o1, o0};
    end

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].r, vecs[i].e, vecs[i].m, 1'b0, 0, 0);
      checkVal("vec_tick", {30'd0, tick}, {30'd0, vecs[i].exp_tick});
      checkVal("vec_clk_out", {30'd0, clk_out}, {30'd0, vecs[i].exp_out});
    end

    // Mid-period write of 3 to ch0: the running period of 4 completes first.
    applyStimulus(1'b0, 2'b11, 2'b10, 1'b0, 0, 0);
    applyStimulus(1'b0, 2'b11, 2'b10, 1'b1, 0, 3);
    idle(8, 2'b11, 2'b10);
    checkSeq("midperiod_write_tick0", 0, 21, 30, 32'h248);
    checkSeq("midperiod_write_tick1", 2, 21, 30, 32'h88);

    // Write of 5 on ch0's wrap edge: one more period of 3, then 5.
    idle(2, 2'b11, 2'b10);
    applyStimulus(1'b0, 2'b11, 2'b10, 1'b1, 0, 5);
    idle(13, 2'b11, 2'b10);
    checkSeq("wrap_write_tick0", 0, 31, 46, 32'h8424);

    // Divisor 0 then 1 in pulse mode, then toggle mode at the fastest rate.
    applyStimulus(1'b0, 2'b11, 2'b11, 1'b1, 0, 0);
    idle(9, 2'b11, 2'b11);
    checkSeq("div0_tick0", 0, 47, 56, 32'h3F0);
    checkSeq("div0_pulse_out0", 1, 47, 56, 32'h3F0);
    applyStimulus(1'b0, 2'b11, 2'b11, 1'b1, 0, 1);
    idle(2, 2'b11, 2'b11);
    idle(4, 2'b11, 2'b10);
    checkSeq("div1_tick0", 0, 57, 63, 32'h7F);
    checkSeq("div1_toggle_out0", 1, 60, 63, 32'hA);

    // Back to 4, then ch0 disabled for 5 cycles with its counter at 2.
    applyStimulus(1'b0, 2'b11, 2'b10, 1'b1, 0, 4);
    idle(3, 2'b11, 2'b10);
    idle(5, 2'b10, 2'b10);
    idle(3, 2'b11, 2'b10);
    checkSeq("disable_tick0", 0, 64, 75, 32'h403);
    checkSeq("disable_hold_out0", 1, 64, 75, 32'h3FE);

    // Pending write of 7 discarded by reset; period returns to 4.
    applyStimulus(1'b0, 2'b11, 2'b10, 1'b1, 0, 7);
    applyStimulus(1'b1, 2'b11, 2'b10, 1'b0, 0, 0);
    checkVal("reset_outputs", {28'd0, tick, clk_out}, 32'd0);
    idle(12, 2'b11, 2'b00);
    checkSeq("after_reset_tick0", 0, 1, 12, 32'h888);
    checkSeq("after_reset_out0", 1, 1, 12, 32'h878);

    checkVal("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
